// File: rtl/gbar_unit.sv
// Global barrier responder: collects per-core arrivals per barrier ID and emits a one-cycle release.
// Optional GBAR_PERF_EN adds release and wait-cycle performance counters.
module gbar_unit #(
    parameter int NUM_BARRIERS = 4,
    parameter int NUM_CORES    = 4,
    localparam int NB_BITS     = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1,
    localparam int NC_BITS     = $clog2(NUM_CORES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    input  logic [NB_BITS-1:0] req_id,
    input  logic [NC_BITS-1:0] req_size_m1,
    input  logic [NC_BITS-1:0] req_core_id,
    output logic               req_ready,
    output logic               rsp_valid,
    output logic [NB_BITS-1:0] rsp_id
`ifdef GBAR_PERF_EN
    ,
    output logic [31:0]        perf_releases,
    output logic [31:0]        perf_wait_cycles
`endif
);

    typedef enum logic {S_IDLE, S_FILL} bstate_t;

    bstate_t              state_q [NUM_BARRIERS];
    bstate_t              state_d [NUM_BARRIERS];
    logic [NUM_CORES-1:0] mask_q  [NUM_BARRIERS];
    logic [NUM_CORES-1:0] mask_d  [NUM_BARRIERS];
    logic [NC_BITS-1:0]   size_q  [NUM_BARRIERS];
    logic [NC_BITS-1:0]   size_d  [NUM_BARRIERS];
    logic                 rsp_valid_q, rsp_valid_d;
    logic [NB_BITS-1:0]   rsp_id_q, rsp_id_d;

    logic                 fire;
    logic [31:0]          id_ext;
    logic                 id_ok;
    bstate_t              sel_state;
    logic [NUM_CORES-1:0] sel_mask;
    logic [NC_BITS-1:0]   sel_size;
    logic [NC_BITS-1:0]   cur_size;
    logic [NUM_CORES-1:0] new_mask;
    logic                 release_now;

    function automatic logic [NC_BITS:0] popcount(input logic [NUM_CORES-1:0] m);
        logic [NC_BITS:0] c;
        c = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            c = c + (NC_BITS+1)'(m[i]);
        end
        return c;
    endfunction

    assign req_ready = reset;
    assign fire      = req_valid && req_ready;
    assign id_ext    = 32'(req_id);
    assign id_ok     = id_ext < 32'(NUM_BARRIERS);

    always_comb begin
        sel_state = S_IDLE;
        sel_mask  = '0;
        sel_size  = '0;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            if (id_ext == 32'(b)) begin
                sel_state = state_q[b];
                sel_mask  = mask_q[b];
                sel_size  = size_q[b];
            end
        end
        // The first arrival of a phase fixes the participant count.
        cur_size    = (sel_state == S_IDLE) ? req_size_m1 : sel_size;
        new_mask    = sel_mask | (NUM_CORES'(1) << req_core_id);
        release_now = fire && id_ok &&
                      (popcount(new_mask) == (NC_BITS+1)'(cur_size) + (NC_BITS+1)'(1));
    end

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        size_d      = size_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            if (fire && id_ext == 32'(b)) begin
                if (release_now) begin
                    state_d[b] = S_IDLE;
                    mask_d[b]  = '0;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = NB_BITS'(b);
                end else begin
                    state_d[b] = S_FILL;
                    mask_d[b]  = new_mask;
                    size_d[b]  = cur_size;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                state_q[b] <= S_IDLE;
                mask_q[b]  <= '0;
                size_q[b]  <= '0;
            end
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            size_q      <= size_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;

`ifdef GBAR_PERF_EN
    logic [31:0] releases_q, releases_d;
    logic [31:0] wait_q, wait_d;
    logic [31:0] fill_cnt;

    always_comb begin
        fill_cnt = '0;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            fill_cnt = fill_cnt + 32'(state_q[b] == S_FILL);
        end
        releases_d = releases_q + 32'(rsp_valid_d);
        wait_d     = wait_q + fill_cnt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            releases_q <= '0;
            wait_q     <= '0;
        end else begin
            releases_q <= releases_d;
            wait_q     <= wait_d;
        end
    end

    assign perf_releases    = releases_q;
    assign perf_wait_cycles = wait_q;
`endif

endmodule
